// File: rtl/mode_status_ctrl_if.sv
// Button-pulse inputs and mode/status outputs of the mode sequencer.
// Latency: none, signal bundle only.
// Backpressure: none; buttons are single-cycle pulses, outputs are levels/pulses.
interface mode_status_ctrl_if #(
    parameter int MW = 2
);
    logic          btn_next;
    logic          btn_prev;
    logic [MW-1:0] mode;
    logic          mode_changed;
    logic          led_status;

    // Driver side: button debouncers feed pulses, display logic consumes mode/status
    modport master (
        output btn_next,
        output btn_prev,
        input  mode,
        input  mode_changed,
        input  led_status
    );

    // Sequencer side
    modport slave (
        input  btn_next,
        input  btn_prev,
        output mode,
        output mode_changed,
        output led_status
    );
endinterface

// File: rtl/mode_status_ctrl.sv
// Mode sequencer with idle auto-return and a burst-coded status LED (m+1 blinks in mode m).
// Latency: mode/mode_changed/led_status update one clock after the causing button pulse or tick.
// Backpressure: none; every single button pulse is acted on, simultaneous next+prev is dropped.
module mode_status_ctrl #(
    parameter int NUM_MODES   = 4,
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BLINK_HZ    = 2,
    parameter int GAP_HALVES  = 4,
    parameter int IDLE_HALVES = 120,
    parameter int MW          = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    mode_status_ctrl_if.slave   bus
);

    localparam int HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GW   = ($clog2(GAP_HALVES + 1) > 1) ? $clog2(GAP_HALVES + 1) : 1;
    localparam int IW   = ($clog2(IDLE_HALVES + 1) > 1) ? $clog2(IDLE_HALVES + 1) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_HALVES - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_HALVES);
    localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_HALVES > 0) ? IDLE_HALVES - 1 : 0);
    localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        ST_ON  = 2'd0,
        ST_OFF = 2'd1,
        ST_GAP = 2'd2
    } state_t;

    state_t        state_q;
    logic [MW-1:0] mode_q, mode_d;
    logic          mode_changed_q;
    logic          led_q;
    logic [DW-1:0] div_cnt_q;
    logic [MW-1:0] pulse_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    logic tick;
    logic btn_evt;
    logic idle_en;
    logic timeout;
    logic mode_chg;

    // Half-period tick, idle-timeout detection and single-button qualification
    always_comb begin
        tick    = (div_cnt_q == DIV_LAST);
        btn_evt = bus.btn_next ^ bus.btn_prev;
        idle_en = (IDLE_HALVES > 0) && (mode_q != '0);
        timeout = idle_en && tick && (idle_cnt_q >= IDLE_LAST);
    end

    // Next mode and idle counter; a button wins over a coincident timeout
    always_comb begin
        mode_d     = mode_q;
        idle_cnt_d = idle_cnt_q;
        if (bus.btn_next && !bus.btn_prev) begin
            mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
        end else if (bus.btn_prev && !bus.btn_next) begin
            mode_d = (mode_q == '0) ? MODE_LAST : mode_q - 1'b1;
        end else if (timeout) begin
            mode_d = '0;
        end
        mode_chg = (mode_d != mode_q);

        if (btn_evt || timeout || !idle_en) begin
            idle_cnt_d = '0;
        end else if (tick && (idle_cnt_q != IDLE_MAX)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    // Mode register, prescaler and blink FSM; a mode change restarts the burst at ON
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q         <= '0;
            mode_changed_q <= 1'b0;
            led_q          <= 1'b0;
            div_cnt_q      <= '0;
            pulse_cnt_q    <= '0;
            gap_cnt_q      <= '0;
            idle_cnt_q     <= '0;
            state_q        <= ST_GAP;
        end else begin
            mode_q         <= mode_d;
            mode_changed_q <= mode_chg;
            idle_cnt_q     <= idle_cnt_d;
            if (mode_chg) begin
                div_cnt_q   <= '0;
                pulse_cnt_q <= '0;
                state_q     <= ST_ON;
                led_q       <= 1'b1;
            end else begin
                div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
                if (tick) begin
                    case (state_q)
                        ST_ON: begin
                            led_q <= 1'b0;
                            if (pulse_cnt_q == mode_q) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= '0;
                            end else begin
                                state_q     <= ST_OFF;
                                pulse_cnt_q <= pulse_cnt_q + 1'b1;
                            end
                        end
                        ST_OFF: begin
                            state_q <= ST_ON;
                            led_q   <= 1'b1;
                        end
                        ST_GAP: begin
                            if (gap_cnt_q == GAP_LAST) begin
                                state_q     <= ST_ON;
                                pulse_cnt_q <= '0;
                                led_q       <= 1'b1;
                            end else begin
                                gap_cnt_q <= gap_cnt_q + 1'b1;
                                led_q     <= 1'b0;
                            end
                        end
                        default: begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= '0;
                            led_q     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.mode         = mode_q;
    assign bus.mode_changed = mode_changed_q;
    assign bus.led_status   = led_q;

endmodule

// File: tb/tb_mode_status_ctrl.sv
// Bench for mode_status_ctrl: button stepping, wrap, idle return, reset abort, blink pattern.
// Latency: outputs observed on the falling edge after each rising edge.
// Backpressure: none.
module tb_mode_status_ctrl;

    localparam int NM   = 3;
    localparam int HALF = 5;
    localparam int GAP  = 4;

    logic clk;
    logic rst;

    mode_status_ctrl_if #(.MW(2)) bus();

    mode_status_ctrl #(
        .NUM_MODES   (NM),
        .CLK_FREQ_HZ (100),
        .BLINK_HZ    (10),
        .GAP_HALVES  (GAP),
        .IDLE_HALVES (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       r;
        logic       nx;
        logic       pv;
        logic [1:0] m;
        logic       c;
        logic       l;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // LED level k cycles after a burst start; start_half shifts the phase (1 = just after reset)
    function automatic int exp_led(input int m, input int start_half, input int k);
        int h;
        h = ((k / HALF) + start_half) % (2 * m + 1 + GAP);
        return ((h < 2 * m + 1) && (h % 2 == 0)) ? 1 : 0;
    endfunction

    task automatic press(input logic nx, input logic pv);
        bus.btn_next = nx;
        bus.btn_prev = pv;
        @(negedge clk);
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
    endtask

    task automatic run_check(input int m, input int start_half, input bit chg_first,
                             input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s mode k=%0d", tag, k), bus.mode, m);
            chk($sformatf("%s chg k=%0d", tag, k), bus.mode_changed, (chg_first && k == 0) ? 1 : 0);
            chk($sformatf("%s led k=%0d", tag, k), bus.led_status, exp_led(m, start_half, k));
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;

        //            r     nx    pv    mode  chg   led
        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);

        // Single-cycle vectors: reset, stepping both ways, wrap, simultaneous press
        for (int i = 0; i < 9; i++) begin
            rst          = tbl[i].r;
            bus.btn_next = tbl[i].nx;
            bus.btn_prev = tbl[i].pv;
            @(negedge clk);
            chk($sformatf("vec%0d mode", i), bus.mode, tbl[i].m);
            chk($sformatf("vec%0d chg", i), bus.mode_changed, tbl[i].c);
            chk($sformatf("vec%0d led", i), bus.led_status, tbl[i].l);
        end
        rst          = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;

        // After reset: 20 cycles dark, then 5 on / 20 off
        run_check(0, 1, 1'b0, 55, "init");

        // Three next presses: 1, 2, 0
        press(1'b1, 1'b0);
        run_check(1, 0, 1'b1, 50, "next1");
        press(1'b1, 1'b0);
        run_check(2, 0, 1'b1, 50, "next2");
        press(1'b1, 1'b0);
        run_check(0, 0, 1'b1, 10, "next3");

        // prev from mode 0 wraps to the top; both buttons together are ignored
        press(1'b0, 1'b1);
        run_check(2, 0, 1'b1, 3, "prev_wrap");
        press(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("both mode k=%0d", k), bus.mode, 2);
            chk($sformatf("both chg k=%0d", k), bus.mode_changed, 0);
            @(negedge clk);
        end

        // Idle return: mode 1 falls back to 0 after 100 cycles
        press(1'b1, 1'b0);
        run_check(0, 0, 1'b1, 2, "to0");
        press(1'b1, 1'b0);
        run_check(1, 0, 1'b1, 100, "idle");
        chk("idle ret mode", bus.mode, 0);
        chk("idle ret chg", bus.mode_changed, 1);
        chk("idle ret led", bus.led_status, 1);
        @(negedge clk);
        chk("idle ret chg end", bus.mode_changed, 0);
        chk("idle ret mode hold", bus.mode, 0);

        // A press at cycle 90 restarts the idle count
        press(1'b1, 1'b0);
        run_check(1, 0, 1'b1, 89, "pre_restart");
        press(1'b1, 1'b0);
        run_check(2, 0, 1'b1, 100, "restart");
        chk("restart ret mode", bus.mode, 0);
        chk("restart ret chg", bus.mode_changed, 1);
        @(negedge clk);

        // Reset mid-burst in mode 2 aborts to the reset state and replays the initial gap
        press(1'b0, 1'b1);
        run_check(2, 0, 1'b1, 12, "burst");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst mode", bus.mode, 0);
        chk("midrst chg", bus.mode_changed, 0);
        chk("midrst led", bus.led_status, 0);
        rst = 1'b0;
        run_check(0, 1, 1'b0, 26, "post_rst");

        // Button landing on the timeout edge: single pulse, idle counter cleared
        press(1'b0, 1'b1);
        run_check(2, 0, 1'b1, 99, "pre_to");
        press(1'b1, 1'b0);
        chk("to_btn idle_cnt", dut.idle_cnt_q, 0);
        run_check(0, 0, 1'b1, 30, "to_btn");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
